// File: rtl/ni_packetizer.sv
// Injection-side network interface: turns a packet request plus payload words
// into head/body/tail flits for the router local port, under credit flow control.
module ni_packetizer #(
  parameter int X_WIDTH    = 2,
  parameter int Y_WIDTH    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [X_WIDTH-1:0]    id_x,
  input  logic [Y_WIDTH-1:0]    id_y,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [X_WIDTH:0]      req_dst_x,
  input  logic [Y_WIDTH:0]      req_dst_y,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  flit_valid,
  output logic [DATA_WIDTH+1:0] flit_out,
  input  logic                  credit_in,
  output logic                  credit_err
);

  localparam int CNT_WIDTH = $clog2(BUF_DEPTH + 1);
  localparam int HEAD_BITS = 2 * (X_WIDTH + 1) + X_WIDTH + Y_WIDTH + LEN_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CREDIT_MAX = CNT_WIDTH'(BUF_DEPTH);

  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEAD,
    S_BODY
  } state_e;

  state_e                  state_q;
  logic [X_WIDTH:0]        dst_x_q;
  logic [Y_WIDTH:0]        dst_y_q;
  logic [X_WIDTH-1:0]      src_x_q;
  logic [Y_WIDTH-1:0]      src_y_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    rem_q;
  logic [CNT_WIDTH-1:0]    credits_q, credits_d;
  logic                    credit_err_q, credit_err_d;
  logic                    flit_valid_q;
  logic [DATA_WIDTH+1:0]   flit_q, flit_d;

  logic                    has_credit;
  logic                    head_send;
  logic                    body_send;
  logic                    send;
  logic [HEAD_BITS-1:0]    head_fields;

  assign has_credit  = (credits_q != '0);
  assign head_send   = (state_q == S_HEAD) && has_credit;
  assign body_send   = (state_q == S_BODY) && has_credit && data_valid;
  assign send        = head_send || body_send;

  // Route computation reads these fields LSB first; upper payload bits stay zero.
  assign head_fields = {len_q, src_y_q, src_x_q, dst_y_q, dst_x_q};

  // NOTE: each signal driven here gets a default first so no latch is inferred.
  always_comb begin
    flit_d = flit_q;
    if (head_send) begin
      flit_d = {(len_q == '0) ? FLIT_SINGLE : FLIT_HEAD, DATA_WIDTH'(head_fields)};
    end else if (body_send) begin
      flit_d = {(rem_q == LEN_WIDTH'(1)) ? FLIT_TAIL : FLIT_BODY, data_in};
    end
  end

  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    if (send && !credit_in) begin
      credits_d = credits_q - 1'b1;
    end else if (!send && credit_in) begin
      // A returned credit with a full counter means the router and NI disagree.
      if (credits_q == CREDIT_MAX) begin
        credit_err_d = 1'b1;
      end else begin
        credits_d = credits_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dst_x_q      <= '0;
      dst_y_q      <= '0;
      src_x_q      <= '0;
      src_y_q      <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      credits_q    <= CREDIT_MAX;
      credit_err_q <= 1'b0;
      flit_valid_q <= 1'b0;
      flit_q       <= '0;
    end else begin
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      flit_valid_q <= send;
      flit_q       <= flit_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            dst_x_q <= req_dst_x;
            dst_y_q <= req_dst_y;
            src_x_q <= id_x;
            src_y_q <= id_y;
            len_q   <= req_len;
            state_q <= S_HEAD;
          end
        end
        S_HEAD: begin
          if (has_credit) begin
            rem_q   <= len_q;
            state_q <= (len_q == '0) ? S_IDLE : S_BODY;
          end
        end
        S_BODY: begin
          if (body_send) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == LEN_WIDTH'(1)) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign data_ready = (state_q == S_BODY) && has_credit;
  assign flit_valid = flit_valid_q;
  assign flit_out   = flit_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_ni_packetizer.sv
// Bench for ni_packetizer: head-flit vector table, multi-cycle corner sequences,
// then random packets scored against a flit-queue and credit-count model.
module tb_ni_packetizer;

  localparam int XW = 2;
  localparam int YW = 2;
  localparam int DW = 32;
  localparam int LW = 4;
  localparam int BD = 4;
  localparam int FW = DW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [XW-1:0] id_x;
  logic [YW-1:0] id_y;
  logic          req_valid;
  logic          req_ready;
  logic [XW:0]   req_dst_x;
  logic [YW:0]   req_dst_y;
  logic [LW-1:0] req_len;
  logic          data_valid;
  logic          data_ready;
  logic [DW-1:0] data_in;
  logic          flit_valid;
  logic [FW-1:0] flit_out;
  logic          credit_in;
  logic          credit_err;

  ni_packetizer #(
    .X_WIDTH(XW), .Y_WIDTH(YW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .BUF_DEPTH(BD)
  ) dut (
    .clk(clk), .rst(rst), .id_x(id_x), .id_y(id_y),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_len(req_len),
    .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
    .flit_valid(flit_valid), .flit_out(flit_out),
    .credit_in(credit_in), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task check_bit(input string name, input logic act, input logic exp);
    check(name, 64'(act), 64'(exp));
  endtask

  task check_flit(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    check(name, 64'(act), 64'(exp));
  endtask

  task step();
    @(posedge clk);
    #1;
  endtask

  task expect_flit(input string name, input logic [FW-1:0] exp);
    check_bit(name, flit_valid, 1'b1);
    check_flit(name, flit_out, exp);
  endtask

  task give_credits(input int n);
    credit_in = 1'b1;
    repeat (n) step();
    credit_in = 1'b0;
  endtask

  task send_req(input logic [XW:0] dx, input logic [YW:0] dy, input logic [LW-1:0] len);
    req_dst_x = dx;
    req_dst_y = dy;
    req_len   = len;
    req_valid = 1'b1;
    check_bit("req_ready_idle", req_ready, 1'b1);
    step();
    req_valid = 1'b0;
  endtask

  // Head payload from the field layout, with plain arithmetic on field offsets.
  function automatic logic [DW-1:0] head_model(int dx, int dy, int sx, int sy, int len);
    longint v;
    int pos_dy, pos_sx, pos_sy, pos_len;
    pos_dy  = XW + 1;
    pos_sx  = pos_dy + YW + 1;
    pos_sy  = pos_sx + XW;
    pos_len = pos_sy + YW;
    v = longint'(dx) + longint'(dy) * (64'd1 << pos_dy) + longint'(sx) * (64'd1 << pos_sx)
      + longint'(sy) * (64'd1 << pos_sy) + longint'(len) * (64'd1 << pos_len);
    return DW'(v);
  endfunction

  typedef struct {
    logic [XW-1:0] id_x;
    logic [YW-1:0] id_y;
    logic [XW:0]   dst_x;
    logic [YW:0]   dst_y;
    logic [FW-1:0] exp_flit;
  } vec_t;

  vec_t          vec[5];
  logic [DW-1:0] dw[6];

  typedef enum {P_IDLE, P_HEAD, P_BODY} phase_e;
  phase_e        phase_m;
  int            credits_m;
  int            idx_m;
  int            budget;
  logic [FW-1:0] exp_q[$];
  logic [DW-1:0] words[16];
  logic [XW:0]   rdx;
  logic [YW:0]   rdy;
  logic [LW-1:0] rlen;

  // One random cycle: predict the send from model credits, compare, then update the model.
  task rtick();
    logic exp_send;
    credit_in = (credits_m < BD) && ($urandom_range(0, 2) == 0);
    exp_send  = (credits_m > 0) &&
                ((phase_m == P_HEAD) || ((phase_m == P_BODY) && data_valid));
    step();
    check_bit("rand_flit_valid", flit_valid, exp_send);
    if (exp_send) begin
      check_flit("rand_flit_out", flit_out, exp_q[0]);
      void'(exp_q.pop_front());
      if (phase_m == P_BODY) idx_m++;
      phase_m = (exp_q.size() == 0) ? P_IDLE : P_BODY;
    end else if ((phase_m == P_IDLE) && req_valid) begin
      phase_m = P_HEAD;
    end
    if (exp_send && !credit_in) credits_m--;
    else if (!exp_send && credit_in) credits_m++;
    check_bit("rand_data_ready", data_ready, (phase_m == P_BODY) && (credits_m > 0));
    check_bit("rand_req_ready", req_ready, phase_m == P_IDLE);
    check_bit("rand_credit_err", credit_err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{2'd1, 2'd2, 3'd3, 3'd0, 34'h3_0000_0243};
    vec[1] = '{2'd0, 2'd0, 3'd0, 3'd0, 34'h3_0000_0000};
    vec[2] = '{2'd3, 2'd3, 3'd7, 3'd7, 34'h3_0000_03FF};
    vec[3] = '{2'd2, 2'd1, 3'd2, 3'd1, 34'h3_0000_018A};
    vec[4] = '{2'd1, 2'd0, 3'd4, 3'd5, 34'h3_0000_006C};
    for (int i = 0; i < 6; i++) dw[i] = 32'hC0DE_0000 + 32'(i);

    rst = 1'b1; id_x = '0; id_y = '0; req_valid = 1'b0; req_dst_x = '0; req_dst_y = '0;
    req_len = '0; data_valid = 1'b0; data_in = '0; credit_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_bit("reset_flit_valid", flit_valid, 1'b0);
    check_flit("reset_flit_out", flit_out, '0);
    check_bit("reset_credit_err", credit_err, 1'b0);
    check_bit("reset_req_ready", req_ready, 1'b1);
    check_bit("reset_data_ready", data_ready, 1'b0);

    // Head-only packets: packing, self-addressing, destination MSBs passed through.
    for (int i = 0; i < 5; i++) begin
      id_x = vec[i].id_x;
      id_y = vec[i].id_y;
      send_req(vec[i].dst_x, vec[i].dst_y, 4'd0);
      check_bit("vec_no_flit_on_accept", flit_valid, 1'b0);
      check_bit("vec_req_ready_busy", req_ready, 1'b0);
      step();
      expect_flit("vec_head", vec[i].exp_flit);
      check_bit("vec_req_ready_back", req_ready, 1'b1);
      give_credits(1);
      check_bit("vec_flit_one_cycle", flit_valid, 1'b0);
      check_flit("vec_flit_hold", flit_out, vec[i].exp_flit);
      check_bit("vec_credit_err", credit_err, 1'b0);
    end

    // Three-word packet streamed every cycle; uses three of four credits plus the head.
    id_x = 2'd1; id_y = 2'd2;
    send_req(3'd3, 3'd0, 4'd3);
    data_valid = 1'b1; data_in = dw[0];
    step();
    expect_flit("p3_head", 34'h1_0000_0E43);
    check_bit("p3_data_ready", data_ready, 1'b1);
    step(); expect_flit("p3_body_a", {2'b00, dw[0]}); data_in = dw[1];
    step(); expect_flit("p3_body_b", {2'b00, dw[1]}); data_in = dw[2];
    step(); expect_flit("p3_tail_c", {2'b10, dw[2]}); data_valid = 1'b0;
    check_bit("p3_data_ready_end", data_ready, 1'b0);
    check_bit("p3_req_ready_end", req_ready, 1'b1);

    // Credits are now zero: a head-only packet must wait for a returned credit.
    send_req(3'd3, 3'd0, 4'd0);
    step(); check_bit("head_stall_1", flit_valid, 1'b0);
    step(); check_bit("head_stall_2", flit_valid, 1'b0);
    give_credits(1);
    check_bit("head_stall_3", flit_valid, 1'b0);
    step(); expect_flit("head_after_credit", 34'h3_0000_0243);
    give_credits(BD);
    check_bit("p3_credit_err", credit_err, 1'b0);

    // Six-word packet against four credits, then single credits and a simultaneous send/return.
    send_req(3'd2, 3'd3, 4'd6);
    data_valid = 1'b1; data_in = dw[0];
    step(); expect_flit("p6_head", 34'h1_0000_1A5A);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_flit("p6_body", {2'b00, dw[i]});
      data_in = dw[i+1];
    end
    check_bit("p6_stall_ready", data_ready, 1'b0);
    step(); check_bit("p6_stall_flit", flit_valid, 1'b0);
    give_credits(1);
    check_bit("p6_credit_flit", flit_valid, 1'b0);
    check_bit("p6_credit_ready", data_ready, 1'b1);
    step(); expect_flit("p6_body_3", {2'b00, dw[3]});
    check_bit("p6_ready_after_one", data_ready, 1'b0);
    data_in = dw[4];
    step(); check_bit("p6_exactly_one", flit_valid, 1'b0);
    credit_in = 1'b1;
    step(); check_bit("p6_credit2_flit", flit_valid, 1'b0);
    step(); expect_flit("p6_body_4", {2'b00, dw[4]});
    check_bit("p6_simul_unchanged", data_ready, 1'b1);
    credit_in = 1'b0; data_in = dw[5];
    step(); expect_flit("p6_tail", {2'b10, dw[5]});
    data_valid = 1'b0;
    give_credits(BD);
    check_bit("p6_credit_err", credit_err, 1'b0);

    // Extra credit at a full counter: saturates and sets the sticky error.
    give_credits(1);
    check_bit("ovf_err_set", credit_err, 1'b1);
    send_req(3'd0, 3'd1, 4'd4);
    data_valid = 1'b1; data_in = dw[0];
    step(); expect_flit("ovf_head", 34'h1_0000_1248);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_flit("ovf_body", {2'b00, dw[i]});
      data_in = dw[i+1];
    end
    check_bit("ovf_saturated", data_ready, 1'b0);
    step(); check_bit("ovf_stall", flit_valid, 1'b0);
    give_credits(1);
    step(); expect_flit("ovf_tail", {2'b10, dw[3]});
    data_valid = 1'b0;
    give_credits(BD);
    check_bit("ovf_err_sticky", credit_err, 1'b1);

    // Reset after the second body flit of a five-word packet.
    send_req(3'd1, 3'd1, 4'd5);
    data_valid = 1'b1; data_in = dw[0];
    step(); expect_flit("rst_head", 34'h1_0000_1649);
    step(); expect_flit("rst_body_0", {2'b00, dw[0]}); data_in = dw[1];
    step(); expect_flit("rst_body_1", {2'b00, dw[1]});
    rst = 1'b1;
    #1;
    check_bit("rst_flit_valid", flit_valid, 1'b0);
    check_flit("rst_flit_out", flit_out, '0);
    check_bit("rst_credit_err", credit_err, 1'b0);
    check_bit("rst_req_ready", req_ready, 1'b1);
    check_bit("rst_data_ready", data_ready, 1'b0);
    data_valid = 1'b0;
    step();
    rst = 1'b0;
    check_bit("rst_release_ready", req_ready, 1'b1);
    send_req(3'd0, 3'd0, 4'd3);
    data_valid = 1'b1; data_in = dw[2];
    step(); expect_flit("rst_next_head", 34'h1_0000_0E40);
    step(); expect_flit("rst_next_b0", {2'b00, dw[2]}); data_in = dw[3];
    step(); expect_flit("rst_next_b1", {2'b00, dw[3]}); data_in = dw[4];
    step(); expect_flit("rst_next_tail", {2'b10, dw[4]});
    data_valid = 1'b0;
    give_credits(BD);
    check_bit("rst_next_credit_err", credit_err, 1'b0);

    // Two-word packet with a three-cycle gap between payload words.
    send_req(3'd3, 3'd3, 4'd2);
    data_valid = 1'b1; data_in = dw[0];
    step(); expect_flit("gap_head", 34'h1_0000_0A5B);
    step(); expect_flit("gap_body", {2'b00, dw[0]});
    data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_bit("gap_no_flit", flit_valid, 1'b0);
    end
    check_flit("gap_hold", flit_out, {2'b00, dw[0]});
    data_valid = 1'b1; data_in = dw[1];
    step(); expect_flit("gap_tail", {2'b10, dw[1]});
    data_valid = 1'b0;
    check_bit("gap_req_ready", req_ready, 1'b1);
    give_credits(3);
    check_bit("gap_credit_err", credit_err, 1'b0);

    // Random packets, payload gaps and credit returns against the model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    phase_m   = P_IDLE;
    credits_m = BD;
    for (int p = 0; p < 40; p++) begin
      rdx  = 3'($urandom_range(0, 7));
      rdy  = 3'($urandom_range(0, 7));
      id_x = 2'($urandom_range(0, 3));
      id_y = 2'($urandom_range(0, 3));
      rlen = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      exp_q.delete();
      exp_q.push_back({(rlen == 4'd0) ? 2'b11 : 2'b01,
                       head_model(int'(rdx), int'(rdy), int'(id_x), int'(id_y), int'(rlen))});
      for (int i = 0; i < int'(rlen); i++) begin
        words[i] = $urandom();
        exp_q.push_back({(i == int'(rlen) - 1) ? 2'b10 : 2'b00, words[i]});
      end
      req_dst_x = rdx; req_dst_y = rdy; req_len = rlen; req_valid = 1'b1;
      idx_m = 0;
      check_bit("rand_req_ready_idle", req_ready, 1'b1);
      rtick();
      req_valid = 1'b0;
      budget = 0;
      while ((phase_m != P_IDLE) && (budget < 400)) begin
        data_valid = ($urandom_range(0, 3) != 0);
        data_in    = (idx_m < int'(rlen)) ? words[idx_m] : $urandom();
        rtick();
        budget++;
      end
      data_valid = 1'b0;
      repeat ($urandom_range(0, 2)) rtick();
    end
    credit_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
